// File: rtl/data_io_wide_if.sv
// RAM write port of the download block: one word per wr/wr_ack handshake.
interface data_io_wide_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 25
) ();
    logic                    wr;
    logic                    wr_ack;
    logic [ADDR_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   d;
    logic [DATA_WIDTH/8-1:0] be;

    modport master (output wr, a, d, be, input wr_ack);
    modport slave  (input wr, a, d, be, output wr_ack);
endinterface

// File: rtl/data_io_wide.sv
// SPI file-download port: packs bytes into DATA_WIDTH words, buffers and writes them to RAM.
// Optional running byte checksum is built only when DATA_IO_CHECKSUM_EN is defined.
module data_io_wide #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 25,
    parameter int START_ADDR = 0,
    parameter int FIFO_DEPTH = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spi_sck,
    input  logic          spi_ss,
    input  logic          spi_sdi,
    output logic          downloading,
    output logic [7:0]    index,
    output logic          overflow,
    output logic [15:0]   checksum,
    data_io_wide_if.master ram
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
        logic [NB-1:0]         be;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

    // SPI oversampling and byte framing
    logic [1:0] r_sck_sync, r_ss_sync, r_sdi_sync;
    logic       r_sck_prev, r_done, r_have_cmd;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift, r_cmd;
    logic       w_sck_rise;

    assign w_sck_rise = r_sck_sync[1] & ~r_sck_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync <= 2'b00;
            r_ss_sync  <= 2'b11;
            r_sdi_sync <= 2'b00;
            r_sck_prev <= 1'b0;
            r_done     <= 1'b0;
            r_bitcnt   <= 3'd0;
            r_shift    <= 8'h00;
            r_have_cmd <= 1'b0;
            r_cmd      <= 8'h00;
        end else begin
            r_sck_sync <= {r_sck_sync[0], spi_sck};
            r_ss_sync  <= {r_ss_sync[0], spi_ss};
            r_sdi_sync <= {r_sdi_sync[0], spi_sdi};
            r_sck_prev <= r_sck_sync[1];
            r_done     <= 1'b0;
            if (r_ss_sync[1]) begin
                r_bitcnt   <= 3'd0;
                r_shift    <= 8'h00;
                r_have_cmd <= 1'b0;
                r_cmd      <= 8'h00;
            end else begin
                if (w_sck_rise) begin
                    r_shift  <= {r_shift[6:0], r_sdi_sync[1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    r_done   <= (r_bitcnt == 3'd7);
                end
                // r_shift holds the full byte during the cycle r_done is high
                if (r_done && !r_have_cmd) begin
                    r_cmd      <= r_shift;
                    r_have_cmd <= 1'b1;
                end
            end
        end
    end

    state_t                r_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_pack_d, w_word;
    logic [NB-1:0]         r_pack_be, w_be;
    logic [CW-1:0]         r_pack_cnt;
    logic                  w_stb, w_start, w_end, w_dat, w_idx, w_last, w_push;
    int                    w_lane;
    entry_t                w_push_e, w_head;
    entry_t                r_mem [FIFO_DEPTH];
    logic [PW:0]           r_wptr, r_rptr;
    logic                  w_empty, w_full, w_pop;
    logic                  r_wr, r_overflow;
    logic [7:0]            r_index;
    logic [ADDR_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_d;
    logic [NB-1:0]         r_be;

    always_comb begin
        w_stb   = r_done & r_have_cmd;
        w_start = w_stb && (r_cmd == 8'h53) && r_shift[0];
        w_end   = w_stb && (r_cmd == 8'h53) && !r_shift[0] && (r_state == S_LOAD);
        w_dat   = w_stb && (r_cmd == 8'h54) && (r_state == S_LOAD);
        w_idx   = w_stb && (r_cmd == 8'h55);
        w_lane  = BIG_ENDIAN ? (NB - 1 - int'(r_pack_cnt)) : int'(r_pack_cnt);
        w_last  = (int'(r_pack_cnt) == NB - 1);
        w_word  = r_pack_d;
        w_be    = r_pack_be;
        for (int l = 0; l < NB; l++) begin
            if (l == w_lane) begin
                w_word[l*8 +: 8] = r_shift;
                w_be[l]          = 1'b1;
            end
        end
        w_push      = (w_dat && w_last) || (w_end && (|r_pack_be));
        w_push_e.a  = r_addr;
        w_push_e.d  = w_dat ? w_word : r_pack_d;
        w_push_e.be = w_dat ? {NB{1'b1}} : r_pack_be;
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_pop   = r_wr & ram.wr_ack;
    assign w_head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push && !w_full)
            r_mem[r_wptr[PW-1:0]] <= w_push_e;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_start) begin
            w_state_nx = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  if (w_end) w_state_nx = S_DRAIN;
                S_DRAIN: if (w_empty && !r_wr) w_state_nx = S_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= ADDR_WIDTH'(START_ADDR);
            r_pack_d   <= '0;
            r_pack_be  <= '0;
            r_pack_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wr       <= 1'b0;
            r_overflow <= 1'b0;
            r_index    <= 8'h00;
            r_a        <= '0;
            r_d        <= '0;
            r_be       <= '0;
        end else begin
            if (w_idx) r_index <= r_shift;
            if (w_start) begin
                // restart: drop anything still queued, including the word on the bus
                r_addr     <= ADDR_WIDTH'(START_ADDR);
                r_pack_d   <= '0;
                r_pack_be  <= '0;
                r_pack_cnt <= '0;
                r_overflow <= 1'b0;
                r_rptr     <= r_wptr;
                r_wr       <= 1'b0;
            end else begin
                if (w_dat) begin
                    if (w_last) begin
                        r_pack_d   <= '0;
                        r_pack_be  <= '0;
                        r_pack_cnt <= '0;
                        r_addr     <= r_addr + ADDR_WIDTH'(NB);
                    end else begin
                        r_pack_d   <= w_word;
                        r_pack_be  <= w_be;
                        r_pack_cnt <= r_pack_cnt + CW'(1);
                    end
                end else if (w_end) begin
                    r_pack_d   <= '0;
                    r_pack_be  <= '0;
                    r_pack_cnt <= '0;
                end
                if (w_push) begin
                    if (w_full) r_overflow <= 1'b1;
                    else        r_wptr     <= r_wptr + (PW+1)'(1);
                end
                // head entry stays in the FIFO until acked
                if (w_pop) begin
                    r_wr   <= 1'b0;
                    r_rptr <= r_rptr + (PW+1)'(1);
                end else if (!r_wr && !w_empty) begin
                    r_wr <= 1'b1;
                    r_a  <= w_head.a;
                    r_d  <= w_head.d;
                    r_be <= w_head.be;
                end
            end
        end
    end

`ifdef DATA_IO_CHECKSUM_EN
    logic [15:0] r_checksum;
    always_ff @(posedge clk) begin
        if (reset || w_start) r_checksum <= 16'h0000;
        else if (w_dat)       r_checksum <= r_checksum + {8'h00, r_shift};
    end
    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

    assign downloading = (r_state != S_IDLE);
    assign index       = r_index;
    assign overflow    = r_overflow;
    assign ram.wr      = r_wr;
    assign ram.a       = r_a;
    assign ram.d       = r_d;
    assign ram.be      = r_be;
endmodule

// File: tb/tb_data_io_wide.sv
// Scoreboard bench: two data_io_wide instances (16-bit LE at 0, 32-bit BE at 100) share one SPI stream.
module tb_data_io_wide;
    logic clk = 1'b0, reset = 1'b1;
    logic spi_sck = 1'b0, spi_ss = 1'b1, spi_sdi = 1'b0;
    logic dl0, dl1, ov0, ov1;
    logic [7:0] ix0, ix1;
    logic [15:0] ck0, ck1;

    always #5 clk = ~clk;

    data_io_wide_if #(.DATA_WIDTH(16), .ADDR_WIDTH(25)) ram0 ();
    data_io_wide_if #(.DATA_WIDTH(32), .ADDR_WIDTH(25)) ram1 ();

    data_io_wide #(.DATA_WIDTH(16), .ADDR_WIDTH(25), .START_ADDR(0), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_sdi(spi_sdi),
        .downloading(dl0), .index(ix0), .overflow(ov0), .checksum(ck0), .ram(ram0));
    data_io_wide #(.DATA_WIDTH(32), .ADDR_WIDTH(25), .START_ADDR(100), .FIFO_DEPTH(4), .BIG_ENDIAN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_sdi(spi_sdi),
        .downloading(dl1), .index(ix1), .overflow(ov1), .checksum(ck1), .ram(ram1));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
    wr_t exq0[$], exq1[$];
    logic [7:0] m_stream[$];
    logic [7:0] tx[$];
    int  wc[2], held[2];
    bit  m_ovf[2];
    bit  m_load = 0, ack_en = 1;
    logic [7:0]  m_idx = 8'h00;
    logic [15:0] m_ck = 16'h0000;

    task automatic emit(input int k, input int n);
        wr_t e;
        int nb = (k == 0) ? 2 : 4;
        int first = wc[k] * nb;
        int lane;
        e.a  = (((k == 0) ? 0 : 100) + first) & 32'h01FF_FFFF;
        e.d  = 32'h0;
        e.be = 4'h0;
        for (int j = 0; j < n; j++) begin
            lane = (k == 0) ? j : nb - 1 - j;
            e.d[lane*8 +: 8] = m_stream[first + j];
            e.be[lane] = 1'b1;
        end
        wc[k]++;
        if (!ack_en) begin
            if (held[k] < 4) held[k]++;
            else begin m_ovf[k] = 1; return; end
        end
        if (k == 0) exq0.push_back(e); else exq1.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] cmd, input logic [7:0] b);
        int rem;
        case (cmd)
            8'h53: if (b[0]) begin
                m_load = 1; m_stream.delete(); wc = '{0, 0}; m_ovf = '{0, 0}; m_ck = 16'h0;
            end else if (m_load) begin
                for (int k = 0; k < 2; k++) begin
                    rem = m_stream.size() - wc[k] * ((k == 0) ? 2 : 4);
                    if (rem > 0) emit(k, rem);
                end
                m_load = 0;
            end
            8'h54: if (m_load) begin
                m_stream.push_back(b);
                m_ck = m_ck + {8'h00, b};
                for (int k = 0; k < 2; k++)
                    if (m_stream.size() - wc[k] * ((k == 0) ? 2 : 4) == ((k == 0) ? 2 : 4)) emit(k, (k == 0) ? 2 : 4);
            end
            8'h55: m_idx = b;
            default: ;
        endcase
    endtask

    function automatic logic [15:0] exp_ck();
`ifdef DATA_IO_CHECKSUM_EN
        return m_ck;
`else
        return 16'h0000;
`endif
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sdi = b[i]; cw(3);
            spi_sck = 1'b1; cw(3);
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd);
        spi_ss = 1'b0; cw(3);
        spi_bits(cmd, 8);
        foreach (tx[i]) begin
            model_byte(cmd, tx[i]);
            spi_bits(tx[i], 8);
        end
        cw(3); spi_ss = 1'b1; cw(4);
    endtask

    task automatic one(input logic [7:0] cmd, input logic [7:0] b);
        tx = {b};
        frame(cmd);
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = !dl0 && !dl1 && exq0.size() == 0 && exq1.size() == 0;
        end
        check({name, " drained"}, {31'b0, done}, 32'd1);
    endtask

    // ---------------- ack driver and monitors ----------------
    initial begin
        ram0.wr_ack = 1'b0; ram1.wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            ram0.wr_ack = ack_en && ($urandom_range(0, 1) == 1);
            ram1.wr_ack = ack_en && ($urandom_range(0, 1) == 1);
        end
    end

    logic p0_wr = 0, p0_pop = 0, p1_wr = 0, p1_pop = 0;
    logic [31:0] p0_a, p0_d, p1_a, p1_d;
    logic [3:0]  p0_be, p1_be;

    always @(negedge clk) begin
        wr_t e;
        if (!reset && ram0.wr) begin
            if (p0_wr && !p0_pop) begin
                check("wr0 hold a", {7'b0, ram0.a}, p0_a);
                check("wr0 hold d", {16'b0, ram0.d}, p0_d);
            end
            if (ram0.wr_ack) begin
                if (exq0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wr0 unexpected write a=%h d=%h be=%b", ram0.a, ram0.d, ram0.be);
                end else begin
                    e = exq0.pop_front();
                    check("wr0 a", {7'b0, ram0.a}, e.a);
                    check("wr0 d", {16'b0, ram0.d}, e.d);
                    check("wr0 be", {30'b0, ram0.be}, {28'b0, e.be});
                end
            end
        end
        p0_wr = !reset && ram0.wr; p0_pop = ram0.wr && ram0.wr_ack;
        p0_a = {7'b0, ram0.a}; p0_d = {16'b0, ram0.d}; p0_be = {2'b0, ram0.be};
    end

    always @(negedge clk) begin
        wr_t e;
        if (!reset && ram1.wr) begin
            if (p1_wr && !p1_pop) begin
                check("wr1 hold a", {7'b0, ram1.a}, p1_a);
                check("wr1 hold d", ram1.d, p1_d);
            end
            if (ram1.wr_ack) begin
                if (exq1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wr1 unexpected write a=%h d=%h be=%b", ram1.a, ram1.d, ram1.be);
                end else begin
                    e = exq1.pop_front();
                    check("wr1 a", {7'b0, ram1.a}, e.a);
                    check("wr1 d", ram1.d, e.d);
                    check("wr1 be", {28'b0, ram1.be}, {28'b0, e.be});
                end
            end
        end
        p1_wr = !reset && ram1.wr; p1_pop = ram1.wr && ram1.wr_ack;
        p1_a = {7'b0, ram1.a}; p1_d = ram1.d; p1_be = ram1.be;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        bit seen;
        cw(3);
        @(negedge clk);
        check("reset downloading", {31'b0, dl0}, 32'd0);
        check("reset wr", {30'b0, ram1.wr, ram0.wr}, 32'd0);
        check("reset index", {24'b0, ix0}, 32'd0);
        check("reset overflow", {31'b0, ov0}, 32'd0);
        check("reset a/d", {7'b0, ram0.a} | {16'b0, ram0.d} | ram1.d, 32'd0);
        check("reset be", {30'b0, ram0.be}, 32'd0);
        check("reset checksum", {16'b0, ck0}, 32'd0);
        reset = 1'b0; cw(2);

        // basic 4-byte file
        one(8'h53, 8'h01);
        check("start downloading", {30'b0, dl1, dl0}, 32'd3);
        tx = {8'h11, 8'h22, 8'h33, 8'h44}; frame(8'h54);
        one(8'h53, 8'h00);
        wait_idle("basic");

        // odd length: partial word with zero pad
        one(8'h53, 8'h01);
        tx = {8'hAA, 8'hBB, 8'hCC}; frame(8'h54);
        one(8'h53, 8'h00);
        wait_idle("partial");
        check("checksum0", {16'b0, ck0}, {16'b0, exp_ck()});
        check("checksum1", {16'b0, ck1}, {16'b0, exp_ck()});

        // index command and aborted byte
        one(8'h55, 8'h05);
        check("index0", {24'b0, ix0}, 32'h05);
        check("index1", {24'b0, ix1}, 32'h05);
        one(8'h53, 8'h01);
        one(8'h54, 8'h11);
        spi_ss = 1'b0; cw(3); spi_bits(8'h54, 8); spi_bits(8'hF0, 4); cw(3); spi_ss = 1'b1; cw(4);
        one(8'h54, 8'h22);
        one(8'h53, 8'h00);
        wait_idle("abort");

        // ignored traffic: data outside LOAD, unknown command, restart inside LOAD
        tx = {8'h77, 8'h88}; frame(8'h54);
        one(8'h99, 8'h01);
        one(8'h53, 8'h00);
        one(8'h53, 8'h01);
        one(8'h54, 8'h5A);
        one(8'h53, 8'h01);
        tx = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; frame(8'h54);
        one(8'h53, 8'h00);
        wait_idle("restart");

        // overflow: no acks, 20 bytes
        ack_en = 0; held = '{0, 0}; cw(2);
        one(8'h53, 8'h01);
        tx.delete();
        for (int i = 0; i < 20; i++) tx.push_back(8'($urandom));
        frame(8'h54);
        one(8'h53, 8'h00);
        cw(10);
        check("overflow0", {31'b0, ov0}, {31'b0, m_ovf[0]});
        check("overflow1", {31'b0, ov1}, {31'b0, m_ovf[1]});
        check("queued writes", exq0.size(), 32'd4);
        ack_en = 1;
        wait_idle("overflow");
        check("overflow sticky", {31'b0, ov0}, 32'd1);

        // checksum wrap data, then cleared by a new start
        one(8'h53, 8'h01);
        tx = {8'hFF, 8'hFF, 8'h03}; frame(8'h54);
        one(8'h53, 8'h00);
        wait_idle("cksum");
        check("checksum FF FF 03", {16'b0, ck0}, {16'b0, exp_ck()});
        one(8'h53, 8'h01);
        check("checksum cleared", {16'b0, ck1}, 32'd0);
        check("overflow cleared", {31'b0, ov0}, 32'd0);
        one(8'h53, 8'h00);
        wait_idle("cksum2");

        // randomized files
        for (int it = 0; it < 6; it++) begin
            one(8'h55, 8'($urandom));
            one(8'h53, 8'h01);
            tx.delete();
            for (int i = 0, n = $urandom_range(1, 11); i < n; i++) tx.push_back(8'($urandom));
            frame(8'h54);
            one(8'h53, 8'h00);
            wait_idle("random");
            check("random index", {24'b0, ix1}, {24'b0, m_idx});
            check("random overflow", {30'b0, ov1, ov0}, 32'd0);
            check("random checksum", {16'b0, ck0}, {16'b0, exp_ck()});
        end

        // reset with words queued
        ack_en = 0; held = '{0, 0}; cw(2);
        one(8'h53, 8'h01);
        tx = {8'h10, 8'h20, 8'h30, 8'h40}; frame(8'h54);
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk); seen = ram0.wr; end
        check("wr before reset", {31'b0, seen}, 32'd1);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset wr drop", {30'b0, ram1.wr, ram0.wr}, 32'd0);
        check("reset dl drop", {30'b0, dl1, dl0}, 32'd0);
        exq0.delete(); exq1.delete();
        m_load = 0; m_idx = 8'h00; m_ck = 16'h0; m_ovf = '{0, 0}; m_stream.delete();
        @(posedge clk); #1; reset = 1'b0;
        ack_en = 1;
        cw(60);
        check("post reset index", {24'b0, ix0}, {24'b0, m_idx});
        check("post reset idle", {29'b0, ram0.wr, dl1, dl0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
